// File: rtl/mhc_pkg.sv
// -----------------------------------------------------------------------------
// mhc_pkg
// Shared constants and helpers for the master hex controller.
//   KEY_W      - width of a candidate key (24 bits)
//   NUM_CORES  - number of search cores reporting a key (4)
//   NUM_DIGITS - seven-segment digits needed to show one key (6)
//   SEG_TABLE  - active-low seven-segment patterns for nibbles 0-F
//                (bit 6 = segment g ... bit 0 = segment a)
// -----------------------------------------------------------------------------
package mhc_pkg;

    localparam int unsigned KEY_W      = 24;
    localparam int unsigned NUM_CORES  = 4;
    localparam int unsigned NUM_DIGITS = KEY_W / 4;

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // True when two or more flags are set: clearing the lowest set bit
    // leaves something behind only if another bit was set.
    function automatic logic multi_set(input logic [NUM_CORES-1:0] flags);
        return (flags & (flags - NUM_CORES'(1))) != '0;
    endfunction

endpackage : mhc_pkg

// File: rtl/master_hex_controller_seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
// Combinational nibble to active-low seven-segment pattern lookup.
// Ports:
//   nibble_i - 4-bit value 0-F
//   seg_o    - active-low segments, bit 6 = g ... bit 0 = a
// -----------------------------------------------------------------------------
module seven_seg_decoder
    import mhc_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule : seven_seg_decoder

// File: rtl/master_hex_controller.sv
// -----------------------------------------------------------------------------
// master_hex_controller
// Collects the key found by one of four search cores, registers it, and shows
// it on six active-low seven-segment digits.
//
// Ports:
//   clk                        - single clock, rising edge
//   rst_n                      - asynchronous active-low reset
//   success_state[3:0]         - per-core found flags (bit i-1 = core i)
//   secret_key_1..4[23:0]      - candidate key from each core
//   secret_key[23:0]           - selected key, registered
//   key_valid                  - secret_key holds a selected core's key
//   multi_hit                  - more than one flag set at last sample
//   hex0..hex5[6:0]            - active-low digits, hex0 = secret_key[3:0]
//
// Build option:
//   MHC_STICKY_KEY_EN - when defined, the first nonzero success_state latches
//                       key, key_valid and multi_hit until reset. When not
//                       defined, selection is re-evaluated every cycle.
//
// Lowest-numbered successful core wins. The digit patterns are decoded from
// the next-state key and registered alongside it, so the display and
// secret_key always change on the same edge.
// -----------------------------------------------------------------------------
module master_hex_controller
    import mhc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       success_state,
    input  logic [KEY_W-1:0] secret_key_1,
    input  logic [KEY_W-1:0] secret_key_2,
    input  logic [KEY_W-1:0] secret_key_3,
    input  logic [KEY_W-1:0] secret_key_4,
    output logic [KEY_W-1:0] secret_key,
    output logic             key_valid,
    output logic             multi_hit,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5
);

    logic [KEY_W-1:0] key_sel;
    logic             valid_sel;
    logic             multi_sel;

    logic [KEY_W-1:0] key_q,   key_d;
    logic             valid_q, valid_d;
    logic             multi_q, multi_d;
    logic [6:0]       hex_q [NUM_DIGITS];
    logic [6:0]       hex_d [NUM_DIGITS];

    // Priority selection, lowest index first.
    always_comb begin
        key_sel   = '0;
        valid_sel = 1'b0;
        multi_sel = multi_set(success_state);
        if (success_state[0]) begin
            key_sel   = secret_key_1;
            valid_sel = 1'b1;
        end else if (success_state[1]) begin
            key_sel   = secret_key_2;
            valid_sel = 1'b1;
        end else if (success_state[2]) begin
            key_sel   = secret_key_3;
            valid_sel = 1'b1;
        end else if (success_state[3]) begin
            key_sel   = secret_key_4;
            valid_sel = 1'b1;
        end
    end

    always_comb begin
        key_d   = key_sel;
        valid_d = valid_sel;
        multi_d = multi_sel;
`ifdef MHC_STICKY_KEY_EN
        // Once a key is captured, key_valid doubles as the latch flag.
        if (valid_q) begin
            key_d   = key_q;
            valid_d = valid_q;
            multi_d = multi_q;
        end
`endif
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seven_seg_decoder u_dec (
            .nibble_i (key_d[4*g +: 4]),
            .seg_o    (hex_d[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= SEG_ZERO;
            end
        end else begin
            key_q   <= key_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    assign secret_key = key_q;
    assign key_valid  = valid_q;
    assign multi_hit  = multi_q;
    assign hex0       = hex_q[0];
    assign hex1       = hex_q[1];
    assign hex2       = hex_q[2];
    assign hex3       = hex_q[3];
    assign hex4       = hex_q[4];
    assign hex5       = hex_q[5];

endmodule : master_hex_controller

// File: tb/tb_master_hex_controller.sv
// -----------------------------------------------------------------------------
// tb_master_hex_controller
// Directed vectors with hand-computed expectations for master_hex_controller.
// Inputs change #1 after a rising edge; outputs are checked #1 after the
// following rising edge.
// -----------------------------------------------------------------------------
module tb_master_hex_controller;

    logic        clk;
    logic        rst_n;
    logic [3:0]  success_state;
    logic [23:0] secret_key_1, secret_key_2, secret_key_3, secret_key_4;
    logic [23:0] secret_key;
    logic        key_valid, multi_hit;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int n_checks = 0;
    int n_errors = 0;

    master_hex_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .success_state (success_state),
        .secret_key_1  (secret_key_1),
        .secret_key_2  (secret_key_2),
        .secret_key_3  (secret_key_3),
        .secret_key_4  (secret_key_4),
        .secret_key    (secret_key),
        .key_valid     (key_valid),
        .multi_hit     (multi_hit),
        .hex0          (hex0),
        .hex1          (hex1),
        .hex2          (hex2),
        .hex3          (hex3),
        .hex4          (hex4),
        .hex5          (hex5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply success_state, then look at the result one edge later.
    task automatic step(input logic [3:0] ss);
        success_state = ss;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_key"},   32'(secret_key), 32'h0);
        check_val({tag, "_valid"}, 32'(key_valid),  32'h0);
        check_val({tag, "_multi"}, 32'(multi_hit),  32'h0);
        check_val({tag, "_hex"},   {4'h0, hex5, hex4, hex3, hex2},
                  {4'h0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
        check_val({tag, "_hexlo"}, {18'h0, hex1, hex0}, {18'h0, 7'b1000000, 7'b1000000});
    endtask

    initial begin
        rst_n         = 1'b0;
        success_state = 4'b0001;
        secret_key_1  = 24'h000006;
        secret_key_2  = 24'h000013;
        secret_key_3  = 24'h000008;
        secret_key_4  = 24'h00000F;

        // Reset held across edges with a nonzero request pending.
        @(posedge clk);
        #1;
        check_reset_vals("por");

        #3 rst_n = 1'b1;

`ifdef MHC_STICKY_KEY_EN
        step(4'b0000);
        check_val("st_idle_valid", 32'(key_valid), 32'h0);
        step(4'b0100);
        check_val("st_first_key",  32'(secret_key), 32'h000008);
        check_val("st_first_valid", 32'(key_valid), 32'h1);
        step(4'b0001);
        check_val("st_hold_key1",  32'(secret_key), 32'h000008);
        step(4'b0000);
        check_val("st_hold_key0",  32'(secret_key), 32'h000008);
        check_val("st_hold_valid", 32'(key_valid),  32'h1);
        check_val("st_hold_hex0",  32'(hex0),       32'(7'b0000000));
        secret_key_3 = 24'h00FFFF;
        step(4'b0110);
        check_val("st_hold_multi", 32'(multi_hit),  32'h0);
        check_val("st_hold_key2",  32'(secret_key), 32'h000008);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("st_rst");
        #3 rst_n = 1'b1;
        step(4'b0110);
        check_val("st_relatch_key",   32'(secret_key), 32'h000013);
        check_val("st_relatch_multi", 32'(multi_hit),  32'h1);
`else
        step(4'b0000);
        check_val("idle_key",   32'(secret_key), 32'h0);
        check_val("idle_valid", 32'(key_valid),  32'h0);
        check_val("idle_hex0",  32'(hex0),       32'(7'b1000000));

        step(4'b0001);
        check_val("c1_key",   32'(secret_key), 32'h000006);
        check_val("c1_valid", 32'(key_valid),  32'h1);
        check_val("c1_multi", 32'(multi_hit),  32'h0);
        check_val("c1_hex0",  32'(hex0),       32'(7'b0000010));

        step(4'b0010);
        check_val("c2_key",   32'(secret_key), 32'h000013);
        check_val("c2_valid", 32'(key_valid),  32'h1);
        check_val("c2_hex1",  32'(hex1),       32'(7'b1111001));
        check_val("c2_hex0",  32'(hex0),       32'(7'b0110000));

        step(4'b0100);
        check_val("c3_key",  32'(secret_key), 32'h000008);
        check_val("c3_hex0", 32'(hex0),       32'(7'b0000000));

        step(4'b1000);
        check_val("c4_key",   32'(secret_key), 32'h00000F);
        check_val("c4_valid", 32'(key_valid),  32'h1);
        check_val("c4_hex0",  32'(hex0),       32'(7'b0001110));

        step(4'b0110);
        check_val("m23_key",   32'(secret_key), 32'h000013);
        check_val("m23_multi", 32'(multi_hit),  32'h1);

        step(4'b1111);
        check_val("mall_key",   32'(secret_key), 32'h000006);
        check_val("mall_multi", 32'(multi_hit),  32'h1);

        step(4'b1100);
        check_val("m34_key",   32'(secret_key), 32'h000008);
        check_val("m34_multi", 32'(multi_hit),  32'h1);

        // Key changes while core 1 stays successful; covers every digit.
        secret_key_1 = 24'hABCDEF;
        step(4'b0001);
        check_val("abc_key",   32'(secret_key), 32'hABCDEF);
        check_val("abc_multi", 32'(multi_hit),  32'h0);
        check_val("abc_hex54", {18'h0, hex5, hex4}, {18'h0, 7'b0001000, 7'b0000011});
        check_val("abc_hex32", {18'h0, hex3, hex2}, {18'h0, 7'b1000110, 7'b0100001});
        check_val("abc_hex10", {18'h0, hex1, hex0}, {18'h0, 7'b0000110, 7'b0001110});

        secret_key_1 = 24'h123456;
        step(4'b0001);
        check_val("h12_key",   32'(secret_key), 32'h123456);
        check_val("h12_hex54", {18'h0, hex5, hex4}, {18'h0, 7'b1111001, 7'b0100100});
        check_val("h12_hex32", {18'h0, hex3, hex2}, {18'h0, 7'b0110000, 7'b0011001});
        check_val("h12_hex10", {18'h0, hex1, hex0}, {18'h0, 7'b0010010, 7'b0000010});

        secret_key_1 = 24'h789000;
        step(4'b0001);
        check_val("h78_key",   32'(secret_key), 32'h789000);
        check_val("h78_hex54", {18'h0, hex5, hex4}, {18'h0, 7'b1111000, 7'b0000000});
        check_val("h78_hex3",  32'(hex3), 32'(7'b0010000));

        step(4'b0000);
        check_val("drop_key",   32'(secret_key), 32'h0);
        check_val("drop_valid", 32'(key_valid),  32'h0);
        check_val("drop_hex5",  32'(hex5),       32'(7'b1000000));

        // Reset between edges while a key is valid.
        step(4'b0010);
        check_val("pre_rst_valid", 32'(key_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        #3 rst_n = 1'b1;
        step(4'b0100);
        check_val("post_rst_key",   32'(secret_key), 32'h000008);
        check_val("post_rst_valid", 32'(key_valid),  32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_master_hex_controller
